pipe_final_adder: RTL and testbench
===================================

# pipe_final_adder

Parametrised, pipelined carry-propagate adder for the final stage of the Wallace-tree multipliers. It adds the two WIDTH-bit rows left by the reduction tree, one SEG-bit segment per pipeline stage, with the carry registered between stages. Operands and result move through a valid/ready handshake with full backpressure. It replaces the fixed 10-bit combinational final adder and serves 5x5 and wider tree multipliers at higher clock rates.

## Interface
- WIDTH, 10: operand and sum width in bits, ≥ 2.
- SEG, 4: bits added per pipeline stage, 1..WIDTH.
- NSTG, derived as ceil(WIDTH/SEG): number of pipeline stages. Not overridable.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  adder accepts operands this cycle.
- a  in  WIDTH  operand row 0.
- b  in  WIDTH  operand row 1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

## Operation
- Segment k covers bits [min((k+1)*SEG, WIDTH)-1 : k*SEG]. The last segment is narrower when SEG does not divide WIDTH.
- Stage k, for k = 0..NSTG-1:
  - adds segment k of a and b with the carry registered by stage k-1 (0 for stage 0);
  - registers the segment sum, the carry out, and the still-unprocessed upper operand bits;
  - passes along the sum bits already completed by earlier stages.
- Each stage holds one valid bit. Stage k loads when its upstream holds valid data and stage k is empty or is passing its own data on in the same cycle.
- in_ready = !v[0] | adv[0], where adv[k] means stage k's data moves on this cycle. adv[NSTG-1] = out_valid & out_ready.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready through the advance chain, by design.
- out_valid = v[NSTG-1]. s and cout come straight from the last stage registers.
- While out_valid is high and out_ready is low, s and cout hold stable. Holding stages do not lose data and do not duplicate it.
- Results are delivered in acceptance order.

## Timing
- Reset: every v[k] goes to 0; s = 0, cout = 0, out_valid = 0. in_ready is 1 once reset is released.
- Latency: operands accepted in cycle t give out_valid in cycle t+NSTG, when there is no backpressure.
- Throughput: one result per cycle while out_ready stays high.
- Full pipeline with out_ready low:
  - all stages hold;
  - in_ready = 0;
  - an in_valid presented during this time is not consumed.
- Full pipeline with out_ready going high: the output transfers and a new input is accepted in the same cycle.
- Bubbles: empty stages are filled even while the output is stalled, so at most NSTG results are held.
- Reset asserted mid-operation: in-flight data is discarded immediately and all valids clear asynchronously. No partial result appears after rst_n rises.
- Arithmetic: {cout, s} = a + b, exact, WIDTH+1 bits.

## Configuration
- PIPE_FINAL_ADDER_SAT_EN defined:
  - when the final carry is 1, s = all ones;
  - cout still reports the true carry;
  - saturation is applied in the last stage, with no added latency.
- Not defined: s wraps modulo 2^WIDTH and no saturation logic is built.

## Structure
- Package pipe_final_adder_pkg:
  - function nstg(width, seg), the ceiling division used for NSTG;
  - function seg_lo(k, seg) and seg_hi(k, seg, width), giving segment bounds.
- Sub-module pfa_stage: one segment adder plus its valid/data registers and advance logic, parametrised by segment index. The top module generates NSTG instances of it and ties the handshake chain together.

## Test plan
- WIDTH=10, SEG=4 (NSTG=3): a=429, b=339, out_ready=1 -> out_valid exactly 3 cycles after acceptance; s=768, cout=0.
- a=1023, b=1023 -> s=10'h3FE, cout=1 without the macro; s=10'h3FF, cout=1 with PIPE_FINAL_ADDER_SAT_EN.
- Back-to-back stream a=i, b=2i for i=0..20 with out_ready=1 -> one result per cycle, s=3i mod 1024, in order, in_ready always 1.
- Hold out_ready=0 while streaming -> exactly 3 accepted, then in_ready=0. s stays stable while stalled. Releasing out_ready delivers all results in order with no loss and no duplicates.
- Pulse rst_n low with 2 operands in flight -> out_valid=0, s=0, cout=0 immediately. No stale result after release. The next operand pair gives the correct sum after 3 cycles.
- WIDTH=13, SEG=5 (last segment 3 bits): a=8191, b=1 -> s=0, cout=1, latency 3.

Source files
------------

// File: rtl/pipe_final_adder_pkg.sv
// Shared helpers for the pipelined final adder: stage count and segment bounds.
package pipe_final_adder_pkg;

  localparam int unsigned DefWidth = 10;
  localparam int unsigned DefSeg   = 4;

  // Number of pipeline stages: ceil(width / seg).
  function automatic int unsigned nstg(input int unsigned width, input int unsigned seg);
    return (width + seg - 1) / seg;
  endfunction

  // Lowest bit index covered by segment k.
  function automatic int unsigned seg_lo(input int unsigned k, input int unsigned seg);
    return k * seg;
  endfunction

  // Highest bit index covered by segment k; the last segment may be narrower.
  function automatic int unsigned seg_hi(input int unsigned k, input int unsigned seg,
                                         input int unsigned width);
    int unsigned top;
    top = (k + 1) * seg;
    if (top > width) top = width;
    return top - 1;
  endfunction

endpackage

// File: rtl/pfa_stage.sv
// One pipeline stage of the final adder: adds segment K of the operands with the
// incoming carry, and holds the partial sum, carry and remaining operand bits.
module pfa_stage
  import pipe_final_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG   = DefSeg,
  parameter int unsigned K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,     // upstream holds data
  input  logic             i_ready,     // this stage may load this cycle
  input  logic             i_dn_ready,  // downstream takes our data this cycle
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_c,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c
);

  localparam int unsigned Lo   = seg_lo(K, SEG);
  localparam int unsigned Hi   = seg_hi(K, SEG, WIDTH);
  localparam int unsigned SegW = Hi - Lo + 1;
  // Operand bits still to be added by later stages.
  localparam logic [WIDTH-1:0] UpMask = {WIDTH{1'b1}} << (Hi + 1);
  // Sum bits already completed by earlier stages.
  localparam logic [WIDTH-1:0] LoMask = ~({WIDTH{1'b1}} << Lo);

  logic [SegW-1:0] w_seg_a;
  logic [SegW-1:0] w_seg_b;
  logic [SegW:0]   w_sum;
  logic            w_adv;
  logic            w_load;

  logic             r_v;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_c;

  assign w_seg_a = SegW'(i_a >> Lo);
  assign w_seg_b = SegW'(i_b >> Lo);
  assign w_sum   = {1'b0, w_seg_a} + {1'b0, w_seg_b} + {{SegW{1'b0}}, i_c};
  assign w_adv   = r_v & i_dn_ready;
  assign w_load  = i_valid & i_ready;

  // Valid bit and data registers; data only changes when a new word loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
      r_c <= 1'b0;
    end else begin
      if (w_load) begin
        r_v <= 1'b1;
      end else if (w_adv) begin
        r_v <= 1'b0;
      end
      if (w_load) begin
        r_a <= i_a & UpMask;
        r_b <= i_b & UpMask;
        r_s <= (i_s & LoMask) | (WIDTH'(w_sum[SegW-1:0]) << Lo);
        r_c <= w_sum[SegW];
      end
    end
  end

  assign o_valid = r_v;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_s     = r_s;
  assign o_c     = r_c;

endmodule

// File: rtl/pipe_final_adder.sv
// Pipelined carry-propagate final adder for the Wallace-tree multipliers.
// Optional build macro PIPE_FINAL_ADDER_SAT_EN: saturate s to all ones on carry out.
module pipe_final_adder
  import pipe_final_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG   = DefSeg
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned NSTG = nstg(WIDTH, SEG);

  // Index k is the input of stage k; index NSTG is the last stage's output.
  logic             w_v [NSTG+1];
  logic [WIDTH-1:0] w_a [NSTG+1];
  logic [WIDTH-1:0] w_b [NSTG+1];
  logic [WIDTH-1:0] w_s [NSTG+1];
  logic             w_c [NSTG+1];
  // w_rdy[k]: stage k can load; w_rdy[NSTG] is the consumer's ready.
  logic [NSTG:0]    w_rdy;

  assign w_v[0] = in_valid;
  assign w_a[0] = a;
  assign w_b[0] = b;
  assign w_s[0] = '0;
  assign w_c[0] = 1'b0;

  // Ready chain from the output back to the input: a stage can load when empty or
  // when its own data moves on in the same cycle.
  always_comb begin
    w_rdy       = '0;
    w_rdy[NSTG] = out_ready;
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      w_rdy[k] = ~w_v[k+1] | w_rdy[k+1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    pfa_stage #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (w_v[k]),
      .i_ready    (w_rdy[k]),
      .i_dn_ready (w_rdy[k+1]),
      .i_a        (w_a[k]),
      .i_b        (w_b[k]),
      .i_s        (w_s[k]),
      .i_c        (w_c[k]),
      .o_valid    (w_v[k+1]),
      .o_a        (w_a[k+1]),
      .o_b        (w_b[k+1]),
      .o_s        (w_s[k+1]),
      .o_c        (w_c[k+1])
    );
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_v[NSTG];
  assign cout      = w_c[NSTG];

`ifdef PIPE_FINAL_ADDER_SAT_EN
  assign s = w_c[NSTG] ? {WIDTH{1'b1}} : w_s[NSTG];
`else
  assign s = w_s[NSTG];
`endif

endmodule

// File: tb/tb_pipe_final_adder.sv
// Directed self-checking bench for pipe_final_adder (10/4 and 13/5 configurations).
module tb_pipe_final_adder;

  localparam int unsigned W  = 10;
  localparam int unsigned W2 = 13;
`ifdef PIPE_FINAL_ADDER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, cout;
  logic [W-1:0]  a, b, s;
  logic          in_valid13, in_ready13, out_valid13, out_ready13, cout13;
  logic [W2-1:0] a13, b13, s13;

  always #5 clk = ~clk;

  pipe_final_adder #(.WIDTH(W), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
  );

  pipe_final_adder #(.WIDTH(W2), .SEG(5)) dut13 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid13),
    .in_ready  (in_ready13),
    .a         (a13),
    .b         (b13),
    .out_valid (out_valid13),
    .out_ready (out_ready13),
    .s         (s13),
    .cout      (cout13)
  );

  typedef struct packed {
    logic         c;
    logic [W-1:0] s;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  logic last_acc, last_xfer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock cycle: record handshakes before the edge, compare any delivered result.
  task automatic step(input logic [W-1:0] es, input logic ec);
    res_t e;
    #1;
    last_acc  = in_valid && in_ready;
    last_xfer = out_valid && out_ready;
    if (last_acc) exp_q.push_back('{c: ec, s: es});
    if (last_xfer) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(s), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] es, input logic ec);
    int lat;
    int n0;
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    step(es, ec);
    check({tag, "_accept"}, 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step('0, 1'b0);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    n0 = n_out;
    step('0, 1'b0);
    check({tag, "_delivered"}, 32'(n_out - n0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int n0;
    int stalls;
    int lat;
    in_valid = 0; a = '0; b = '0; out_ready = 0;
    in_valid13 = 0; a13 = '0; b13 = '0; out_ready13 = 0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_out_valid13", 32'(out_valid13), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_in_ready13", 32'(in_ready13), 32'd1);

    // Single operations: 429+339=768; 1023+1023=2046
    send_one("basic", 10'd429, 10'd339, 10'd768, 1'b0);
    send_one("max", 10'd1023, 10'd1023, SatEn ? 10'h3FF : 10'h3FE, 1'b1);

    // Back-to-back stream a=i, b=2i
    out_ready = 1'b1;
    stalls = 0;
    n0 = n_out;
    for (int c = 0; c <= 23; c++) begin
      in_valid = (c <= 20);
      a = W'(c);
      b = W'(2 * c);
      step(W'((3 * c) % 1024), 1'b0);
      if (c <= 20 && !last_acc) stalls++;
    end
    in_valid = 1'b0;
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_count", 32'(n_out - n0), 32'd21);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: offer a=100+j, b=j with out_ready low
    out_ready = 1'b0;
    j = 0;
    n0 = n_out;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a = W'(100 + j);
      b = W'(j);
      step(W'(100 + 2 * j), 1'b0);
      if (last_acc) j++;
    end
    check("stall_accepted", 32'(j), 32'd3);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_s", 32'(s), 32'd100);
    for (int c = 0; c < 3; c++) begin
      step(W'(100 + 2 * j), 1'b0);
      if (last_acc) j++;
    end
    check("stall_hold_accepted", 32'(j), 32'd3);
    check("stall_hold_s", 32'(s), 32'd100);
    check("stall_hold_cout", 32'(cout), 32'd0);
    // Release: output moves and the offered operand enters in the same cycle
    out_ready = 1'b1;
    step(W'(100 + 2 * j), 1'b0);
    check("release_accept", 32'(last_acc), 32'd1);
    check("release_xfer", 32'(last_xfer), 32'd1);
    in_valid = 1'b0;
    for (int c = 0; c < 10 && (n_out - n0) < 4; c++) step('0, 1'b0);
    check("release_count", 32'(n_out - n0), 32'd4);
    check("release_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two operands in flight
    in_valid = 1'b1; a = 10'd7; b = 10'd8;
    step(10'd15, 1'b0);
    a = 10'd9; b = 10'd9;
    step(10'd18, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_out;
    for (int c = 0; c < 5; c++) step('0, 1'b0);
    check("no_stale", 32'(n_out - n0), 32'd0);
    send_one("post_reset", 10'd300, 10'd212, 10'd512, 1'b0);

    // WIDTH=13, SEG=5: 8191+1 = 8192
    a13 = 13'd8191; b13 = 13'd1; in_valid13 = 1'b1; out_ready13 = 1'b1;
    #1;
    check("w13_in_ready", 32'(in_ready13), 32'd1);
    @(posedge clk);
    #1;
    in_valid13 = 1'b0;
    lat = 1;
    while (!out_valid13 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w13_latency", 32'(lat), 32'd3);
    check("w13_s", 32'(s13), SatEn ? 32'h1FFF : 32'd0);
    check("w13_cout", 32'(cout13), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
